can_tx_framer: RTL and testbench
================================

Name: can_tx_framer

Overview:
- Serialises a CAN 2.0A standard data frame onto the single-bit bus line, one bit per clock.
- Computes CRC-15, inserts stuff bits, and drives the ACK slot dominant to model a receiving node.
- Sits directly upstream of the bus checker. It produces the bus data and the two qualifier strobes the checker consumes: bit_chk, which marks the stuffing region, and ack, which marks the CRC delimiter cycle.

Parameters:
- ACK_DRIVE, 1: when 1, the ACK slot is driven dominant (0); when 0, it is left recessive (1).
- IFS_BITS, 3: number of recessive intermission bits after EOF.

Ports:
- clock  in  1  system clock; one bit time per rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only while ready=1.
- id  in  11  identifier; bit 10 is sent first.
- dlc  in  4  data length code; values 9..15 are sent as-is but 8 bytes are transmitted.
- data  in  64  payload; byte0 = [63:56], each byte sent MSB first.
- ready  out  1  idle and able to accept start.
- tx_bit  out  1  serial bus value (drives bus.data); 1 = recessive.
- bit_chk  out  1  high while the current tx_bit lies in the stuffing region.
- ack  out  1  one-cycle pulse, coincident with the CRC delimiter bit.
- done  out  1  one-cycle pulse on the last IFS bit.
- crc_out  out  15  CRC of the current/last frame, valid from the first CRC bit onwards.

Behaviour:
- Reset (asynchronous, reset=0):
  - tx_bit=1, ready=1, bit_chk=0, ack=0, done=0, crc_out=0.
  - FSM goes to IDLE; all counters clear.
  - Reset asserted mid-frame aborts the frame immediately: tx_bit=1 and no done pulse.
- Registered outputs: every output is registered.
- Start handshake:
  - start=1 with ready=1 at edge n latches id, dlc and data, and drops ready.
  - SOF (0) appears on tx_bit after edge n+1.
  - start while ready=0 is ignored.
- FSM states and contents:
  - IDLE: tx_bit=1.
  - SOF: 1 bit, 0.
  - ARB: 11 ID bits, then RTR=0.
  - CTRL: IDE=0, r0=0, then 4 DLC bits (MSB first).
  - DATA: 8*min(dlc,8) bits; skipped if the count is 0.
  - CRC: 15 bits, MSB first.
  - CRC_DELIM: 1, with ack=1.
  - ACK_SLOT: ~ACK_DRIVE.
  - ACK_DELIM: 1.
  - EOF: 7 ones.
  - IFS: IFS_BITS ones; done=1 on the final bit.
  - Return to IDLE with ready=1 on the following cycle.
- Per-field bit counters advance only on non-stuff bits.
- CRC:
  - Polynomial 0x4599, init 0.
  - Updated serially on each destuffed bit from SOF through the last DATA bit.
  - The CRC register is frozen (shifted out from a copy) during the CRC field.
- Stuffing:
  - Applies from SOF through the last CRC bit.
  - A run counter tracks consecutive equal transmitted bits, stuff bits included.
  - When the run reaches 5, the next cycle transmits the complement as a stuff bit: the field counter holds and the CRC is not updated.
  - The stuff bit starts a new run of length 1.
  - A stuff bit due after the last CRC bit is still transmitted, before CRC_DELIM.
- bit_chk:
  - 1 on every cycle from SOF through the last CRC bit, including a trailing stuff bit.
  - 0 from CRC_DELIM on and in IDLE.
- Run counter: cleared on entry to SOF; it never counts IDLE bits.
- ack: high only on the CRC_DELIM cycle, so ack=1 always coincides with tx_bit=1.
- done/start overlap: a start in the cycle after done is accepted (back-to-back frames). There is no intermediate idle requirement beyond IFS.

Test Plan:
- Reset check: hold reset=0 then release -> tx_bit=1, ready=1, bit_chk=0, ack=0, done=0 on every cycle until start.
- Dominant ID stuffing: id=0x000, dlc=0 -> tx_bit positions 0..4 = 0, position 5 = stuff 1. No run of 6 equal bits while bit_chk=1.
- Recessive ID stuffing: id=0x7FF, dlc=0 -> position 0 = 0, positions 1..5 = 1, position 6 = stuff 0, then the remaining ID bits continue.
- Full frame: id=0x123, dlc=8, data=0x0123456789ABCDEF.
  - Destuffed stream and crc_out match the bench reference model.
  - ack is high exactly 1 cycle, with tx_bit=1 on that cycle.
  - The next bit is 0, followed by 11 ones.
  - done pulses on the 11th of those ones; ready=1 on the next cycle.
- dlc=12, plus start pulsed mid-frame -> exactly 64 data bits sent. The DLC field carries 1100. The mid-frame start has no effect.
- Reset during DATA, then start with id=0x555, dlc=1 -> tx_bit=1 immediately on reset and no done for the aborted frame. The new frame begins with SOF and completes normally.

Source files
------------

// File: rtl/can_tx_framer.sv
// CAN 2.0A standard data frame transmitter: one bus bit per clock, with CRC-15,
// bit stuffing, a modelled ACK slot and the bit_chk/ack qualifier strobes.
module can_tx_framer #(
  parameter bit          ACK_DRIVE = 1'b1,
  parameter int unsigned IFS_BITS  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] id,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  output logic        ready,
  output logic        tx_bit,
  output logic        bit_chk,
  output logic        ack,
  output logic        done,
  output logic [14:0] crc_out
);

  typedef enum logic [3:0] {
    IDLE, SOF, ARB, CTRL, DATA, CRC, CRC_DELIM, ACK_SLOT, ACK_DELIM, EOF, IFS
  } state_t;

  state_t      state, state_d, field_next;
  logic [6:0]  cnt, cnt_d;
  logic [2:0]  run, run_d;
  logic        last_bit, last_d;
  logic [14:0] crc, crc_d;
  logic [10:0] id_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;

  logic        tx_d, chk_d, ack_d, done_d, ready_d;
  logic [14:0] crc_out_d;
  logic        accept, field_bit, field_end, advance, stuff_region, stuff_now;
  logic [6:0]  data_bits;
  logic [3:0]  arb_idx, crc_idx;
  logic [5:0]  data_idx;

  assign data_bits = dlc_q[3] ? 7'd64 : {1'b0, dlc_q[2:0], 3'b000};
  assign arb_idx   = 4'd10 - cnt[3:0];
  assign data_idx  = 6'd63 - cnt[5:0];
  assign crc_idx   = 4'd14 - cnt[3:0];
  assign accept    = (state == IDLE) && ready && start;

  // Field decode: the unstuffed bit for the current state/counter and where the field ends.
  always_comb begin
    field_bit  = 1'b1;
    field_end  = 1'b0;
    field_next = state;
    case (state)
      SOF: begin
        field_bit  = 1'b0;
        field_end  = 1'b1;
        field_next = ARB;
      end
      ARB: begin
        field_bit  = (cnt == 7'd11) ? 1'b0 : id_q[arb_idx];
        field_end  = (cnt == 7'd11);
        field_next = CTRL;
      end
      CTRL: begin
        case (cnt[2:0])
          3'd2:    field_bit = dlc_q[3];
          3'd3:    field_bit = dlc_q[2];
          3'd4:    field_bit = dlc_q[1];
          3'd5:    field_bit = dlc_q[0];
          default: field_bit = 1'b0;
        endcase
        field_end  = (cnt == 7'd5);
        field_next = (data_bits == 7'd0) ? CRC : DATA;
      end
      DATA: begin
        field_bit  = data_q[data_idx];
        field_end  = (cnt == data_bits - 7'd1);
        field_next = CRC;
      end
      CRC: begin
        field_bit  = crc[crc_idx];
        field_end  = (cnt == 7'd14);
        field_next = CRC_DELIM;
      end
      CRC_DELIM: begin
        field_end  = 1'b1;
        field_next = ACK_SLOT;
      end
      ACK_SLOT: begin
        field_bit  = ~ACK_DRIVE;
        field_end  = 1'b1;
        field_next = ACK_DELIM;
      end
      ACK_DELIM: begin
        field_end  = 1'b1;
        field_next = EOF;
      end
      EOF: begin
        field_end  = (cnt == 7'd6);
        field_next = IFS;
      end
      IFS: begin
        field_end  = (cnt == 7'(IFS_BITS - 1));
        field_next = IDLE;
      end
      default: begin
        field_bit  = 1'b1;
        field_end  = 1'b0;
        field_next = IDLE;
      end
    endcase
  end

  // Next-state, stuffing, CRC and registered-output values.
  // A stuff bit owed after the last CRC bit is emitted while sitting in CRC_DELIM
  // (run==5 is only reachable there straight out of the CRC field).
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    run_d     = run;
    last_d    = last_bit;
    crc_d     = crc;
    tx_d      = 1'b1;
    chk_d     = 1'b0;
    ack_d     = 1'b0;
    done_d    = 1'b0;
    ready_d   = ready;
    crc_out_d = crc_out;
    advance   = 1'b0;
    stuff_region = (state inside {SOF, ARB, CTRL, DATA, CRC}) ||
                   ((state == CRC_DELIM) && (run == 3'd5));
    stuff_now    = stuff_region && (run == 3'd5);

    if (state == IDLE) begin
      ready_d = 1'b1;
      if (accept) begin
        ready_d = 1'b0;
        state_d = SOF;
        cnt_d   = '0;
        run_d   = '0;
        crc_d   = '0;
      end
    end else if (stuff_now) begin
      tx_d   = ~last_bit;
      chk_d  = 1'b1;
      run_d  = 3'd1;
      last_d = ~last_bit;
    end else begin
      tx_d    = field_bit;
      chk_d   = stuff_region;
      advance = 1'b1;
      if (stuff_region) begin
        run_d  = ((run != 3'd0) && (field_bit == last_bit)) ? run + 3'd1 : 3'd1;
        last_d = field_bit;
      end
    end

    if (advance) begin
      if (state inside {SOF, ARB, CTRL, DATA})
        crc_d = {crc[13:0], 1'b0} ^ ((field_bit ^ crc[14]) ? 15'h4599 : 15'h0000);
      if (field_end) begin
        state_d = field_next;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt + 7'd1;
      end
      ack_d  = (state == CRC_DELIM);
      done_d = (state == IFS) && field_end;
    end

    if (state == CRC)
      crc_out_d = crc;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      run      <= '0;
      last_bit <= 1'b1;
      crc      <= '0;
      tx_bit   <= 1'b1;
      bit_chk  <= 1'b0;
      ack      <= 1'b0;
      done     <= 1'b0;
      ready    <= 1'b1;
      crc_out  <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      run      <= run_d;
      last_bit <= last_d;
      crc      <= crc_d;
      tx_bit   <= tx_d;
      bit_chk  <= chk_d;
      ack      <= ack_d;
      done     <= done_d;
      ready    <= ready_d;
      crc_out  <= crc_out_d;
    end
  end

  // Frame contents captured on an accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_q   <= '0;
      dlc_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      id_q   <= id;
      dlc_q  <= dlc;
      data_q <= data;
    end
  end

endmodule

// File: tb/tb_can_tx_framer.sv
// Self-checking bench for can_tx_framer: a queue-based frame model builds the
// expected bus sequence for each frame, compared cycle by cycle.
module tb_can_tx_framer;

  localparam bit          ACK_DRIVE = 1'b1;
  localparam int unsigned IFS_BITS  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] id    = '0;
  logic [3:0]  dlc   = '0;
  logic [63:0] data  = '0;
  logic        ready, tx_bit, bit_chk, ack, done;
  logic [14:0] crc_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic        exp_tx[$];
  logic        exp_chk[$];
  logic        exp_ack[$];
  logic        exp_done[$];
  logic [14:0] model_crc;
  logic        cap_tx[$];
  logic        cap_chk[$];
  logic        cap_ack[$];
  logic        dest[$];

  can_tx_framer #(.ACK_DRIVE(ACK_DRIVE), .IFS_BITS(IFS_BITS)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .id      (id),
    .dlc     (dlc),
    .data    (data),
    .ready   (ready),
    .tx_bit  (tx_bit),
    .bit_chk (bit_chk),
    .ack     (ack),
    .done    (done),
    .crc_out (crc_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic t, input logic c, input logic a, input logic d);
    exp_tx.push_back(t);
    exp_chk.push_back(c);
    exp_ack.push_back(a);
    exp_done.push_back(d);
  endtask

  // Frame model: field list -> CRC -> stuffing -> fixed trailer.
  task automatic build_model(input logic [10:0] fid, input logic [3:0] fdlc, input logic [63:0] fdata);
    logic        s[$];
    logic [14:0] c;
    logic        fb, last;
    int          nbytes, runlen, tail;
    s = {};
    s.push_back(1'b0);
    for (int k = 10; k >= 0; k--) s.push_back(fid[k]);
    s.push_back(1'b0);
    s.push_back(1'b0);
    s.push_back(1'b0);
    for (int k = 3; k >= 0; k--) s.push_back(fdlc[k]);
    nbytes = (fdlc > 4'd8) ? 8 : int'(fdlc);
    for (int k = 0; k < nbytes * 8; k++) s.push_back(fdata[63 - k]);
    c = '0;
    foreach (s[k]) begin
      fb = s[k] ^ c[14];
      c  = {c[13:0], 1'b0};
      if (fb) c = c ^ 15'h4599;
    end
    model_crc = c;
    for (int k = 14; k >= 0; k--) s.push_back(c[k]);
    exp_tx = {}; exp_chk = {}; exp_ack = {}; exp_done = {};
    runlen = 0;
    last   = 1'b0;
    foreach (s[k]) begin
      push_exp(s[k], 1'b1, 1'b0, 1'b0);
      runlen = (runlen > 0 && s[k] == last) ? runlen + 1 : 1;
      last   = s[k];
      if (runlen == 5) begin
        push_exp(~last, 1'b1, 1'b0, 1'b0);
        last   = ~last;
        runlen = 1;
      end
    end
    push_exp(1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(~ACK_DRIVE, 1'b0, 1'b0, 1'b0);
    tail = 8 + int'(IFS_BITS);
    for (int k = 0; k < tail; k++) push_exp(1'b1, 1'b0, 1'b0, k == tail - 1);
  endtask

  // Runs one frame from a negedge with ready=1; ends at the negedge after done.
  task automatic run_frame(input logic [10:0] fid, input logic [3:0] fdlc, input logic [63:0] fdata,
                           input int mid_start, input int abort_at);
    build_model(fid, fdlc, fdata);
    cap_tx = {}; cap_chk = {}; cap_ack = {};
    check("ready_before_start", ready, 1'b1);
    id = fid; dlc = fdlc; data = fdata; start = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    id    = 11'($urandom);
    dlc   = 4'($urandom);
    data  = {$urandom, $urandom};
    check("ready_dropped", ready, 1'b0);
    check("tx_before_sof", tx_bit, 1'b1);
    foreach (exp_tx[i]) begin
      @(posedge clock); @(negedge clock);
      start = (i == mid_start);
      cap_tx.push_back(tx_bit);
      cap_chk.push_back(bit_chk);
      cap_ack.push_back(ack);
      check($sformatf("tx_bit[%0d]", i), tx_bit, exp_tx[i]);
      check($sformatf("bit_chk[%0d]", i), bit_chk, exp_chk[i]);
      check($sformatf("ack[%0d]", i), ack, exp_ack[i]);
      check($sformatf("done[%0d]", i), done, exp_done[i]);
      check($sformatf("ready_busy[%0d]", i), ready, 1'b0);
      if (i == abort_at) return;
    end
    @(posedge clock); @(negedge clock);
    check("ready_after_done", ready, 1'b1);
    check("done_single", done, 1'b0);
    check("tx_idle_after", tx_bit, 1'b1);
    check("crc_out", crc_out, model_crc);
  endtask

  // Removes stuff bits from the captured stream (bit_chk region only).
  task automatic destuff_capture();
    int   runlen;
    logic last, skip;
    dest = {}; runlen = 0; last = 1'b0; skip = 1'b0;
    foreach (cap_tx[i]) begin
      if (cap_chk[i]) begin
        if (skip) begin
          skip = 1'b0; runlen = 1; last = cap_tx[i];
        end else begin
          dest.push_back(cap_tx[i]);
          runlen = (runlen > 0 && cap_tx[i] == last) ? runlen + 1 : 1;
          last   = cap_tx[i];
          if (runlen == 5) skip = 1'b1;
        end
      end
    end
  endtask

  function automatic int max_run_capture();
    int   best, runlen;
    logic last;
    best = 0; runlen = 0; last = 1'b0;
    foreach (cap_tx[i]) begin
      if (cap_chk[i]) begin
        runlen = (runlen > 0 && cap_tx[i] == last) ? runlen + 1 : 1;
        last   = cap_tx[i];
        if (runlen > best) best = runlen;
      end else begin
        runlen = 0;
      end
    end
    return best;
  endfunction

  initial begin
    int          ack_cnt;
    logic [3:0]  dlc_seen;
    // Reset behaviour
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", tx_bit, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_chk", bit_chk, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_crc", crc_out, 15'h0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("idle_tx", tx_bit, 1'b1);
      check("idle_ready", ready, 1'b1);
      check("idle_chk", bit_chk, 1'b0);
      check("idle_done", done, 1'b0);
    end

    // Dominant identifier: five zeros then a recessive stuff bit
    run_frame(11'h000, 4'd0, 64'h0, -1, -1);
    for (int k = 0; k < 5; k++) check($sformatf("dom_pos%0d", k), cap_tx[k], 1'b0);
    check("dom_stuff_pos5", cap_tx[5], 1'b1);
    check("dom_max_run", max_run_capture(), 5);

    // Recessive identifier: SOF, five ones, dominant stuff bit, ID continues
    run_frame(11'h7FF, 4'd0, 64'h0, -1, -1);
    check("rec_pos0", cap_tx[0], 1'b0);
    for (int k = 1; k < 6; k++) check($sformatf("rec_pos%0d", k), cap_tx[k], 1'b1);
    check("rec_stuff_pos6", cap_tx[6], 1'b0);
    check("rec_pos7", cap_tx[7], 1'b1);

    // Full 8-byte frame
    run_frame(11'h123, 4'd8, 64'h0123456789ABCDEF, -1, -1);
    ack_cnt = 0;
    foreach (cap_ack[i]) if (cap_ack[i]) ack_cnt++;
    check("full_ack_count", ack_cnt, 1);
    destuff_capture();
    check("full_destuffed_len", dest.size(), 98);

    // dlc=12 with a start pulse mid-frame
    run_frame(11'($urandom), 4'd12, {$urandom, $urandom}, 30, -1);
    destuff_capture();
    check("dlc12_destuffed_len", dest.size(), 98);
    dlc_seen = {dest[15], dest[16], dest[17], dest[18]};
    check("dlc12_field", dlc_seen, 4'b1100);

    // Randomised back-to-back frames
    for (int n = 0; n < 6; n++)
      run_frame(11'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom}, -1, -1);

    // Reset during DATA aborts the frame
    run_frame(11'h123, 4'd8, {$urandom, $urandom}, -1, 40);
    #2 reset = 1'b0;
    #1;
    check("abort_tx", tx_bit, 1'b1);
    check("abort_chk", bit_chk, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("post_abort_done", done, 1'b0);
      check("post_abort_tx", tx_bit, 1'b1);
      check("post_abort_ready", ready, 1'b1);
    end
    run_frame(11'h555, 4'd1, {$urandom, $urandom}, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
